// File: rtl/modexp_exp_scanner.sv
// Exponent digit scanner: reads exponent words MSW-first from a synchronous RAM
// and streams 4-bit digits MSB-first over valid/ready, with optional leading-zero skip.
module modexp_exp_scanner #(
    parameter int WORD_W       = 16,
    parameter int ADDR_W       = 8,
    parameter int DIG_PER_WORD = WORD_W / 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic              start,
    input  logic [ADDR_W-1:0] n_words,
    input  logic              skip_lz,
    input  logic [WORD_W-1:0] E,
    output logic [ADDR_W-1:0] E_addr,
    output logic [3:0]        e,
    output logic              e_valid,
    input  logic              e_ready,
    output logic              e_last,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = (DIG_PER_WORD > 1) ? $clog2(DIG_PER_WORD) : 1;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        EMIT,
        DONE
    } state_t;

    state_t             state, state_nxt;
    logic [WORD_W-1:0]  shreg;
    logic [CNT_W-1:0]   dig_cnt;
    logic               skipping;

    logic [3:0]         nib;
    logic               last_dig;
    logic               final_dig;
    logic               hide;
    logic               advance;

    assign nib       = shreg[WORD_W-1 -: 4];
    assign last_dig  = (dig_cnt == CNT_W'(DIG_PER_WORD - 1));
    assign final_dig = last_dig && (E_addr == '0);
    // The final digit is never hidden so an all-zero exponent still yields one digit.
    assign hide      = skipping && (nib == 4'h0) && !final_dig;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        e         = 4'h0;
        e_valid   = 1'b0;
        e_last    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        advance   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (n_words == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                busy      = 1'b1;
                state_nxt = LOAD;
            end
            LOAD: begin
                busy      = 1'b1;
                state_nxt = EMIT;
            end
            EMIT: begin
                busy    = 1'b1;
                e       = nib;
                e_valid = !hide;
                e_last  = final_dig;
                advance = hide || e_ready;
                if (advance && last_dig) begin
                    state_nxt = (E_addr == '0) ? DONE : FETCH;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so all registers
    // sample the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            E_addr   <= '0;
            shreg    <= '0;
            dig_cnt  <= '0;
            skipping <= 1'b0;
        end else if (ce) begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start && (n_words != '0)) begin
                        E_addr   <= n_words - ADDR_W'(1);
                        skipping <= skip_lz;
                    end
                end
                LOAD: begin
                    shreg   <= E;
                    dig_cnt <= '0;
                end
                EMIT: begin
                    if (advance) begin
                        shreg   <= shreg << 4;
                        dig_cnt <= dig_cnt + CNT_W'(1);
                        if (!hide) begin
                            skipping <= 1'b0;
                        end
                        if (last_dig && (E_addr != '0)) begin
                            E_addr <= E_addr - ADDR_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_modexp_exp_scanner.sv
// Directed bench for modexp_exp_scanner: RAM model, handshake monitor and
// hand-computed digit sequences.
module tb_modexp_exp_scanner;

    localparam int WORD_W = 16;
    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              ce;
    logic              start;
    logic [ADDR_W-1:0] n_words;
    logic              skip_lz;
    logic [WORD_W-1:0] E;
    logic [ADDR_W-1:0] E_addr;
    logic [3:0]        e;
    logic              e_valid;
    logic              e_ready;
    logic              e_last;
    logic              busy;
    logic              done;

    logic [WORD_W-1:0] mem [0:3];

    int checks = 0;
    int errors = 0;

    // Monitor state
    logic        mon_clr = 1'b0;
    logic [63:0] pack;
    logic [63:0] lmask;
    int          dcnt;
    int          dones;
    logic        vseen;

    modexp_exp_scanner #(.WORD_W(WORD_W), .ADDR_W(ADDR_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .ce      (ce),
        .start   (start),
        .n_words (n_words),
        .skip_lz (skip_lz),
        .E       (E),
        .E_addr  (E_addr),
        .e       (e),
        .e_valid (e_valid),
        .e_ready (e_ready),
        .e_last  (e_last),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    // Synchronous RAM with one-cycle read latency
    always @(posedge clk) E <= mem[E_addr[1:0]];

    // Inputs change 1 time unit after posedge, so negedge sees what the next edge samples
    always @(negedge clk) begin
        if (mon_clr) begin
            pack  = '0;
            lmask = '0;
            dcnt  = 0;
            dones = 0;
            vseen = 1'b0;
        end else if (!rst && ce) begin
            if (e_valid) vseen = 1'b1;
            if (e_valid && e_ready) begin
                pack  = {pack[59:0], e};
                lmask = {lmask[62:0], e_last};
                dcnt++;
            end
            if (done) dones++;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        @(negedge clk);
        #1;
        mon_clr = 1'b0;
    endtask

    task automatic start_scan(input logic [ADDR_W-1:0] n, input logic skip);
        n_words = n;
        skip_lz = skip;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    task automatic run_to_done(input string tag, input bit tog);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            if (tog) e_ready = !e_ready;
            tick();
            if (done) got = 1'b1;
        end
        check({tag, "_done_seen"}, 64'(got), 64'd1);
        e_ready = 1'b1;
        tick();
    endtask

    task automatic check_result(input string tag, input logic [63:0] p, input int n,
                                input logic [63:0] lm);
        check({tag, "_digits"}, pack, p);
        check({tag, "_count"}, 64'(dcnt), 64'(n));
        check({tag, "_last"}, lmask, lm);
        check({tag, "_dones"}, 64'(dones), 64'd1);
    endtask

    initial begin
        rst = 1'b1; ce = 1'b1; start = 1'b0; n_words = '0; skip_lz = 1'b0; e_ready = 1'b1;
        for (int i = 0; i < 4; i++) mem[i] = '0;
        tick();
        tick();
        check("rst_E_addr", 64'(E_addr), 64'd0);
        check("rst_e", 64'(e), 64'd0);
        check("rst_e_valid", 64'(e_valid), 64'd0);
        check("rst_e_last", 64'(e_last), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        rst = 1'b0;
        tick();

        // 1: single word, exact timing
        mem[0] = 16'h1A2B;
        clear_mon();
        start_scan(8'd1, 1'b0);
        check("t1_busy_T", 64'(busy), 64'd1);
        check("t1_valid_T", 64'(e_valid), 64'd0);
        tick();
        check("t1_valid_T1", 64'(e_valid), 64'd0);
        tick();
        check("t1_valid_T2", 64'(e_valid), 64'd1);
        check("t1_e_T2", 64'(e), 64'h1);
        check("t1_last_T2", 64'(e_last), 64'd0);
        tick(); tick(); tick();
        check("t1_e_B", 64'(e), 64'hB);
        check("t1_last_B", 64'(e_last), 64'd1);
        tick();
        check("t1_done_after_B", 64'(done), 64'd1);
        check("t1_busy_done", 64'(busy), 64'd0);
        check("t1_valid_done", 64'(e_valid), 64'd0);
        tick();
        check("t1_done_drop", 64'(done), 64'd0);
        check_result("t1", 64'h1A2B, 4, 64'b0001);

        // 2: two words, leading zeros skipped, inner zeros kept
        mem[1] = 16'h0003; mem[0] = 16'hF00F;
        clear_mon();
        start_scan(8'd2, 1'b1);
        check("t2_addr_first", 64'(E_addr), 64'd1);
        run_to_done("t2", 1'b0);
        check("t2_addr_end", 64'(E_addr), 64'd0);
        check_result("t2", 64'h3F00F, 5, 64'b00001);

        // 3: all-zero exponent, with and without skipping
        mem[1] = 16'h0000; mem[0] = 16'h0000;
        clear_mon();
        start_scan(8'd2, 1'b1);
        run_to_done("t3a", 1'b0);
        check_result("t3a", 64'h0, 1, 64'b1);
        clear_mon();
        start_scan(8'd2, 1'b0);
        run_to_done("t3b", 1'b0);
        check_result("t3b", 64'h0, 8, 64'b00000001);

        // 4: back-pressure on digit A, then ready toggling
        mem[0] = 16'h1A2B;
        clear_mon();
        start_scan(8'd1, 1'b0);
        tick(); tick(); tick();
        check("t4_e_A", 64'(e), 64'hA);
        e_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t4_stall_e", 64'(e), 64'hA);
            check("t4_stall_valid", 64'(e_valid), 64'd1);
            check("t4_stall_last", 64'(e_last), 64'd0);
        end
        run_to_done("t4", 1'b1);
        check_result("t4", 64'h1A2B, 4, 64'b0001);

        // 5: clock-enable freeze, then reset mid-scan, then rescan
        mem[1] = 16'h1234; mem[0] = 16'h5678;
        clear_mon();
        start_scan(8'd2, 1'b0);
        tick(); tick(); tick();
        check("t5_e_pre", 64'(e), 64'h2);
        ce = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t5_frz_e", 64'(e), 64'h2);
            check("t5_frz_valid", 64'(e_valid), 64'd1);
            check("t5_frz_addr", 64'(E_addr), 64'd1);
            check("t5_frz_busy", 64'(busy), 64'd1);
        end
        ce = 1'b1;
        tick();
        check("t5_e_resume", 64'(e), 64'h3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_rst_valid", 64'(e_valid), 64'd0);
        check("t5_rst_busy", 64'(busy), 64'd0);
        check("t5_rst_done", 64'(done), 64'd0);
        check("t5_rst_addr", 64'(E_addr), 64'd0);
        tick();
        check("t5_rst_done2", 64'(done), 64'd0);
        clear_mon();
        start_scan(8'd2, 1'b0);
        run_to_done("t5", 1'b0);
        check_result("t5", 64'h12345678, 8, 64'b00000001);

        // 6: empty exponent, then start while busy
        clear_mon();
        start_scan(8'd0, 1'b0);
        check("t6_done", 64'(done), 64'd1);
        check("t6_busy", 64'(busy), 64'd0);
        tick();
        check("t6_done_drop", 64'(done), 64'd0);
        check("t6_no_valid", 64'(vseen), 64'd0);
        check("t6_dones", 64'(dones), 64'd1);
        mem[0] = 16'h0A2B;
        clear_mon();
        start_scan(8'd1, 1'b0);
        n_words = 8'd3; skip_lz = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        check("t6_busy_keep", 64'(busy), 64'd1);
        check("t6_addr_keep", 64'(E_addr), 64'd0);
        run_to_done("t6", 1'b0);
        check_result("t6", 64'h0A2B, 4, 64'b0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
